// File: rtl/system_multisync.sv
// System/time command service: version and time queries, plus disciplining of
// system time against N_CHAN externally latched timesync channels.
module system_multisync #(
  parameter int CMD_BITS        = 8,
  parameter int CMD_GET_VERSION = 0,
  parameter int CMD_SYNC_TIME   = 1,
  parameter int CMD_GET_TIME    = 2,
  parameter int CMD_GET_LATCH   = 3,
  parameter int RSP_GET_VERSION = 0,
  parameter int RSP_GET_TIME    = 1,
  parameter int RSP_GET_LATCH   = 2,
  parameter int VERSION         = 2,
  parameter int N_CHAN          = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         arg_data,
  output logic                arg_advance,
  input  logic [CMD_BITS-1:0] cmd,
  input  logic                cmd_ready,
  output logic                cmd_done,
  output logic [31:0]         param_data,
  output logic                param_write,
  input  logic [63:0]         time_in,
  output logic [63:0]         time_out,
  output logic                time_out_en,
  input  logic [N_CHAN-1:0]   timesync_pulse_in,
  input  logic [N_CHAN-1:0]   timesync_latch_in
);

  localparam int CH_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

  typedef enum logic [2:0] {IDLE, ARG1, ARG2, OUT1, OUT2, OUT3, DONE} state_t;

  state_t              state, state_nxt;
  logic [CMD_BITS-1:0] cmd_q, cmd_q_nxt;
  logic                bad_q, bad_nxt;
  logic [CH_W-1:0]     ch_q, ch_nxt;
  logic [31:0]         hold_hi, hold_nxt;
  logic [31:0]         tlo_q, tlo_nxt;
  logic [31:0]         param_data_nxt;
  logic                param_write_nxt, cmd_done_nxt, time_out_en_nxt;
  logic [63:0]         time_out_nxt;
  logic                adv_c;

  logic [N_CHAN-1:0]   pulse_sync [SYNC_STAGES];
  logic [N_CHAN-1:0]   latch_sync [SYNC_STAGES];
  logic [N_CHAN-1:0]   pulse_d, latch_d, pulse_evt, latch_evt, sync_clr;
  logic [63:0]         latched_time [N_CHAN];
  logic [N_CHAN-1:0]   latched, overrun;

  logic [63:0]         lt_arg, lt_ch;
  logic                lat_ch, ovr_ch, arg_bad;

  // Target plus the pipeline delay from pin edge to the time_out load
  function automatic logic [63:0] sync_target(input logic [63:0] now,
                                              input logic [63:0] stamp,
                                              input logic [63:0] target);
    return now - stamp + target + 64'(SYNC_STAGES + 2);
  endfunction

  function automatic logic [31:0] rsp_word(input logic [CMD_BITS-1:0] c);
    if (c == CMD_BITS'(CMD_GET_TIME))       return 32'(RSP_GET_TIME);
    else if (c == CMD_BITS'(CMD_GET_LATCH)) return 32'(RSP_GET_LATCH);
    else                                    return 32'(RSP_GET_VERSION);
  endfunction

  // Input synchronisers and edge-detect stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        pulse_sync[s] <= '0;
        latch_sync[s] <= '0;
      end
      pulse_d <= '0;
      latch_d <= '0;
    end else begin
      pulse_sync[0] <= timesync_pulse_in;
      latch_sync[0] <= timesync_latch_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        pulse_sync[s] <= pulse_sync[s-1];
        latch_sync[s] <= latch_sync[s-1];
      end
      pulse_d <= pulse_sync[SYNC_STAGES-1];
      latch_d <= latch_sync[SYNC_STAGES-1];
    end
  end

  assign pulse_evt = pulse_sync[SYNC_STAGES-1] ^ pulse_d;
  assign latch_evt = latch_sync[SYNC_STAGES-1] & ~latch_d;

  // Per-channel capture; a latch rise outranks a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CHAN; i++) latched_time[i] <= '0;
      latched <= '0;
      overrun <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (pulse_evt[i]) begin
          if (!latched[i]) latched_time[i] <= time_in;
          else             overrun[i]      <= 1'b1;
        end
        if (sync_clr[i]) begin
          latched[i] <= 1'b0;
          overrun[i] <= 1'b0;
        end
        if (latch_evt[i]) latched[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    lt_arg = '0;
    lt_ch  = '0;
    lat_ch = 1'b0;
    ovr_ch = 1'b0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (arg_data == 32'(i)) lt_arg = latched_time[i];
      if (ch_q == CH_W'(i)) begin
        lt_ch  = latched_time[i];
        lat_ch = latched[i];
        ovr_ch = overrun[i];
      end
    end
  end

  assign arg_bad = (arg_data >= 32'(N_CHAN));

  always_comb begin
    state_nxt       = state;
    cmd_q_nxt       = cmd_q;
    bad_nxt         = bad_q;
    ch_nxt          = ch_q;
    hold_nxt        = hold_hi;
    tlo_nxt         = tlo_q;
    param_data_nxt  = param_data;
    param_write_nxt = param_write;
    cmd_done_nxt    = 1'b0;
    time_out_nxt    = time_out;
    time_out_en_nxt = 1'b0;
    sync_clr        = '0;
    adv_c           = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_ready && !cmd_done) begin
          cmd_q_nxt = cmd;
          if (cmd == CMD_BITS'(CMD_GET_VERSION)) begin
            param_data_nxt  = 32'(VERSION);
            param_write_nxt = 1'b1;
            state_nxt       = DONE;
          end else if (cmd == CMD_BITS'(CMD_GET_TIME)) begin
            param_data_nxt  = time_in[31:0];
            hold_nxt        = time_in[63:32];
            param_write_nxt = 1'b1;
            state_nxt       = OUT1;
          end else if (cmd == CMD_BITS'(CMD_GET_LATCH)) begin
            adv_c           = 1'b1;
            ch_nxt          = arg_data[CH_W-1:0];
            bad_nxt         = arg_bad;
            param_data_nxt  = lt_arg[31:0];
            hold_nxt        = lt_arg[63:32];
            param_write_nxt = 1'b1;
            state_nxt       = OUT1;
          end else if (cmd == CMD_BITS'(CMD_SYNC_TIME)) begin
            adv_c     = 1'b1;
            ch_nxt    = arg_data[CH_W-1:0];
            bad_nxt   = arg_bad;
            state_nxt = ARG1;
          end else begin
            cmd_done_nxt = 1'b1;
          end
        end
      end
      ARG1: begin
        adv_c     = 1'b1;
        tlo_nxt   = arg_data;
        state_nxt = ARG2;
      end
      ARG2: begin
        adv_c = 1'b1;
        if (!bad_q) begin
          time_out_nxt    = sync_target(time_in, lt_ch, {arg_data, tlo_q});
          time_out_en_nxt = 1'b1;
          for (int i = 0; i < N_CHAN; i++) sync_clr[i] = (ch_q == CH_W'(i));
        end
        cmd_done_nxt = 1'b1;
        state_nxt    = IDLE;
      end
      OUT1: begin
        param_data_nxt  = hold_hi;
        param_write_nxt = 1'b1;
        state_nxt       = (cmd_q == CMD_BITS'(CMD_GET_LATCH)) ? OUT2 : DONE;
      end
      OUT2: begin
        param_data_nxt  = bad_q ? 32'h4 : {30'b0, ovr_ch, lat_ch};
        param_write_nxt = 1'b1;
        state_nxt       = DONE;
      end
      DONE: begin
        param_data_nxt  = rsp_word(cmd_q);
        param_write_nxt = 1'b0;
        cmd_done_nxt    = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arg_advance = adv_c & ~rst;

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_q       <= '0;
      bad_q       <= 1'b0;
      param_data  <= '0;
      param_write <= 1'b0;
      cmd_done    <= 1'b0;
      time_out    <= '0;
      time_out_en <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_q       <= cmd_q_nxt;
      bad_q       <= bad_nxt;
      param_data  <= param_data_nxt;
      param_write <= param_write_nxt;
      cmd_done    <= cmd_done_nxt;
      time_out    <= time_out_nxt;
      time_out_en <= time_out_en_nxt;
    end
  end

  always_ff @(posedge clk) begin
    ch_q    <= ch_nxt;
    hold_hi <= hold_nxt;
    tlo_q   <= tlo_nxt;
  end

endmodule

// File: tb/tb_system_multisync.sv
// Scoreboard bench for system_multisync: stimulus pushes expected words and
// completions; a negedge monitor pops and compares them with cycle stamps.
module tb_system_multisync;

  localparam logic [7:0] C_VER  = 8'd0;
  localparam logic [7:0] C_SYNC = 8'd1;
  localparam logic [7:0] C_TIME = 8'd2;
  localparam logic [7:0] C_LAT  = 8'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] arg_data;
  logic        arg_advance;
  logic [7:0]  cmd;
  logic        cmd_ready;
  logic        cmd_done;
  logic [31:0] param_data;
  logic        param_write;
  logic [63:0] time_in;
  logic [63:0] time_out;
  logic        time_out_en;
  logic [1:0]  pulse;
  logic [1:0]  latch;

  system_multisync dut (
    .clk(clk), .rst(rst), .arg_data(arg_data), .arg_advance(arg_advance),
    .cmd(cmd), .cmd_ready(cmd_ready), .cmd_done(cmd_done),
    .param_data(param_data), .param_write(param_write),
    .time_in(time_in), .time_out(time_out), .time_out_en(time_out_en),
    .timesync_pulse_in(pulse), .timesync_latch_in(latch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_done;
    logic [31:0] data;
    logic        chk_data;
    logic        ten;
    logic [63:0] tout;
    int          cyc;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step  = 0;
  int   c0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %0h expected %0h", nm, step, act, exp);
    end
  endtask

  task automatic push_word(input int c, input logic [31:0] d);
    exp_t e;
    e.is_done = 1'b0; e.data = d; e.chk_data = 1'b1; e.ten = 1'b0; e.tout = '0; e.cyc = c;
    expq.push_back(e);
  endtask

  task automatic push_done(input int c, input logic [31:0] d, input logic ten, input logic [63:0] tout);
    exp_t e;
    e.is_done = 1'b1; e.data = d; e.chk_data = 1'b1; e.ten = ten; e.tout = tout; e.cyc = c;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (param_write || cmd_done) begin
        if (expq.size() == 0) begin
          chk("unexpected_output", 64'({param_write, cmd_done}), 64'd0);
        end else begin
          me = expq.pop_front();
          chk("out_cycle", 64'(cyc), 64'(me.cyc));
          chk("out_kind", 64'(cmd_done), 64'(me.is_done));
          if (me.chk_data) chk("param_data", 64'(param_data), 64'(me.data));
          if (me.is_done) begin
            chk("time_out_en", 64'(time_out_en), 64'(me.ten));
            if (me.ten) chk("time_out", time_out, me.tout);
          end
        end
      end else if (time_out_en) begin
        chk("stray_time_out_en", 64'(time_out_en), 64'd0);
      end
    end
  end

  task automatic start(output int c);
    @(posedge clk); #1;
    c = cyc;
    step++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // C0 drive; arg_advance expected in C0 for arg commands and C1/C2 for SYNC_TIME
  task automatic drive(input logic [7:0] c, input logic [31:0] a0, a1, a2, input int hold);
    cmd = c; cmd_ready = 1'b1; arg_data = a0;
    #1 chk("arg_advance_c0", 64'(arg_advance), 64'(c == C_SYNC || c == C_LAT));
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k > hold) cmd_ready = 1'b0;
      if (k == 1) arg_data = a1;
      if (k == 2) arg_data = a2;
      #1 chk("arg_advance_cn", 64'(arg_advance), 64'(c == C_SYNC && k <= 2));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
    end
    chk("drain", 64'(expq.size()), 64'd0);
    cycles(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_ready = 1'b1; cmd = C_SYNC; arg_data = '0;
    time_in = '0; pulse = '0; latch = '0;
    cycles(3);
    chk("rst_param_data", 64'(param_data), 64'd0);
    chk("rst_param_write", 64'(param_write), 64'd0);
    chk("rst_cmd_done", 64'(cmd_done), 64'd0);
    chk("rst_time_out", time_out, 64'd0);
    chk("rst_time_out_en", 64'(time_out_en), 64'd0);
    chk("rst_arg_advance", 64'(arg_advance), 64'd0);
    cmd_ready = 1'b0;
    rst = 1'b0;
    cycles(2);

    start(c0); push_word(c0+1, 32'd2); push_done(c0+2, 32'd0, 1'b0, '0);
    drive(C_VER, 0, 0, 0, 0); drain();

    time_in = 64'h0000_0001_8000_0000;
    start(c0); push_word(c0+1, 32'h8000_0000); push_word(c0+2, 32'h1);
    push_done(c0+3, 32'd1, 1'b0, '0);
    drive(C_TIME, 0, 0, 0, 0); drain();

    time_in = 64'd1000; pulse[1] = ~pulse[1]; cycles(5);
    latch[1] = 1'b1; cycles(5);
    time_in = 64'd1200;
    start(c0); push_done(c0+3, 32'd1, 1'b1, 64'd5204);
    drive(C_SYNC, 1, 5000, 0, 0); drain();
    start(c0); push_word(c0+1, 32'd1000); push_word(c0+2, 32'd0); push_word(c0+3, 32'd0);
    push_done(c0+4, 32'd2, 1'b0, '0);
    drive(C_LAT, 1, 0, 0, 0); drain();

    time_in = 64'd3000; pulse[0] = ~pulse[0]; cycles(5);
    latch[0] = 1'b1; cycles(5);
    time_in = 64'd4000; pulse[0] = ~pulse[0]; cycles(5);
    start(c0); push_word(c0+1, 32'd3000); push_word(c0+2, 32'd0); push_word(c0+3, 32'd3);
    push_done(c0+4, 32'd2, 1'b0, '0);
    drive(C_LAT, 0, 0, 0, 0); drain();
    start(c0); push_done(c0+3, 32'd2, 1'b1, 64'd1014);
    drive(C_SYNC, 0, 10, 0, 0); drain();
    start(c0); push_word(c0+1, 32'd3000); push_word(c0+2, 32'd0); push_word(c0+3, 32'd0);
    push_done(c0+4, 32'd2, 1'b0, '0);
    drive(C_LAT, 0, 0, 0, 0); drain();

    start(c0); push_word(c0+1, 32'd0); push_word(c0+2, 32'd0); push_word(c0+3, 32'h4);
    push_done(c0+4, 32'd2, 1'b0, '0);
    drive(C_LAT, 2, 0, 0, 0); drain();
    start(c0); push_done(c0+3, 32'd2, 1'b0, '0);
    drive(C_SYNC, 2, 7, 0, 0); drain();

    latch[0] = 1'b0; cycles(5);
    time_in = 64'h0000_0005_0000_1B58;
    pulse[0] = ~pulse[0]; latch[0] = 1'b1; cycles(6);
    start(c0); push_word(c0+1, 32'h1B58); push_word(c0+2, 32'h5); push_word(c0+3, 32'h1);
    push_done(c0+4, 32'd2, 1'b0, '0);
    drive(C_LAT, 0, 0, 0, 0); drain();

    start(c0); push_done(c0+1, 32'd2, 1'b0, '0);
    drive(8'h7, 0, 0, 0, 0); drain();

    start(c0); push_word(c0+1, 32'd2); push_done(c0+2, 32'd0, 1'b0, '0);
    drive(C_VER, 0, 0, 0, 2); drain();
    cycles(3);

    start(c0); push_word(c0+1, 32'h1B58);
    cmd = C_LAT; cmd_ready = 1'b1; arg_data = 0;
    @(posedge clk); #1; cmd_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_param_data", 64'(param_data), 64'd0);
    chk("abort_param_write", 64'(param_write), 64'd0);
    chk("abort_cmd_done", 64'(cmd_done), 64'd0);
    chk("abort_time_out", time_out, 64'd0);
    chk("abort_time_out_en", 64'(time_out_en), 64'd0);
    chk("abort_queue", 64'(expq.size()), 64'd0);
    cycles(2);
    rst = 1'b0;
    cycles(5);

    start(c0); push_word(c0+1, 32'd2); push_done(c0+2, 32'd0, 1'b0, '0);
    drive(C_VER, 0, 0, 0, 0); drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
